// File: rtl/cmd_time_scheduler.sv
// Timestamped command table: holds up to DEPTH {time, payload} entries, scans for the
// earliest future command, issues it with a one-cycle DATA_WR and frees it on REQ_COMM.
module cmd_time_scheduler #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned TIME_W      = 64,
  parameter int unsigned PAYLOAD_W   = 274,
  parameter int unsigned TIME_REZERV = 384,
  parameter int unsigned ADDR_W      = $clog2(DEPTH)
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  input  logic [TIME_W-1:0]    TIME,
  input  logic                 SYS_TIME_UPDATE,
  input  logic                 WR_VALID,
  output logic                 WR_READY,
  input  logic [TIME_W-1:0]    WR_TIME,
  input  logic [PAYLOAD_W-1:0] WR_PAYLOAD,
  input  logic                 REQ_COMM,
  input  logic                 FLUSH,
  output logic                 DATA_WR,
  output logic [TIME_W-1:0]    CMD_TIME_z,
  output logic [PAYLOAD_W-1:0] CMD_PAYLOAD_z,
  output logic [ADDR_W:0]      COUNT,
  output logic                 FULL,
  output logic                 LATE_ERR,
  output logic                 STALE_DROP
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned SUM_W = TIME_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DECIDE} state_e;

  state_e                state_q, state_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  armed_vld_q, armed_vld_d;
  logic [ADDR_W-1:0]     armed_idx_q, armed_idx_d;
  logic [2:0]            req_hist_q, upd_hist_q;
  logic                  req_pend_q, req_pend_d;
  logic                  rescan_pend_q, rescan_pend_d;
  logic [ADDR_W-1:0]     scan_idx_q, scan_idx_d;
  logic                  cand_vld_q, cand_vld_d;
  logic [ADDR_W-1:0]     cand_idx_q, cand_idx_d;
  logic [TIME_W-1:0]     cand_time_q, cand_time_d;
  logic                  data_wr_q, data_wr_d;
  logic [TIME_W-1:0]     cmd_time_q, cmd_time_d;
  logic [PAYLOAD_W-1:0]  cmd_payload_q, cmd_payload_d;
  logic                  late_err_q, late_err_d;
  logic                  stale_drop_q, stale_drop_d;

  logic [TIME_W-1:0]     time_q    [DEPTH];
  logic [PAYLOAD_W-1:0]  payload_q [DEPTH];

  logic                  accept_c, on_time_c, wr_en_c, free_found_c, start_scan_c;
  logic                  req_evt_c, upd_evt_c, full_c;
  logic [ADDR_W-1:0]     free_idx_c;
  logic [SUM_W-1:0]      deadline_c;

  assign full_c     = (count_q == CNT_W'(DEPTH));
  assign WR_READY   = (state_q == ST_IDLE) && !full_c && !FLUSH;
  assign accept_c   = WR_VALID && WR_READY;
  // Widened sum so a deadline near the top of the time range never wraps
  assign deadline_c = {1'b0, TIME} + SUM_W'(TIME_REZERV);
  assign on_time_c  = ({1'b0, WR_TIME} > deadline_c);
  assign wr_en_c    = accept_c && on_time_c;
  assign req_evt_c  = (req_hist_q == 3'b001);
  assign upd_evt_c  = (upd_hist_q == 3'b001);

  always_comb begin
    free_idx_c   = '0;
    free_found_c = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] && !free_found_c) begin
        free_idx_c   = ADDR_W'(i);
        free_found_c = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    count_d       = count_q;
    armed_vld_d   = armed_vld_q;
    armed_idx_d   = armed_idx_q;
    req_pend_d    = req_pend_q;
    rescan_pend_d = rescan_pend_q;
    scan_idx_d    = scan_idx_q;
    cand_vld_d    = cand_vld_q;
    cand_idx_d    = cand_idx_q;
    cand_time_d   = cand_time_q;
    cmd_time_d    = cmd_time_q;
    cmd_payload_d = cmd_payload_q;
    late_err_d    = late_err_q;
    data_wr_d     = 1'b0;
    stale_drop_d  = 1'b0;
    start_scan_c  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_pend_q) begin
          if (armed_vld_q) begin
            valid_d[armed_idx_q] = 1'b0;
            count_d              = count_d - CNT_W'(1);
          end
          armed_vld_d   = 1'b0;
          req_pend_d    = 1'b0;
          rescan_pend_d = 1'b0;
          start_scan_c  = 1'b1;
        end
        // A handshake shown on WR_READY is always honoured, even alongside a consume
        if (accept_c) begin
          if (on_time_c) begin
            valid_d[free_idx_c] = 1'b1;
            count_d             = count_d + CNT_W'(1);
            rescan_pend_d       = !req_pend_q;
          end else begin
            late_err_d = 1'b1;
          end
        end else if (rescan_pend_q) begin
          rescan_pend_d = 1'b0;
          start_scan_c  = 1'b1;
        end
        if (start_scan_c) begin
          state_d    = ST_SCAN;
          scan_idx_d = '0;
          cand_vld_d = 1'b0;
        end
      end
      ST_SCAN: begin
        if (valid_q[scan_idx_q]) begin
          if (time_q[scan_idx_q] > TIME) begin
            if (!cand_vld_q || (time_q[scan_idx_q] < cand_time_q)) begin
              cand_vld_d  = 1'b1;
              cand_idx_d  = scan_idx_q;
              cand_time_d = time_q[scan_idx_q];
            end
          end else if (!(armed_vld_q && (armed_idx_q == scan_idx_q))) begin
            valid_d[scan_idx_q] = 1'b0;
            count_d             = count_q - CNT_W'(1);
            stale_drop_d        = 1'b1;
          end
        end
        if (scan_idx_q == ADDR_W'(DEPTH - 1)) state_d = ST_DECIDE;
        else                                  scan_idx_d = scan_idx_q + ADDR_W'(1);
      end
      ST_DECIDE: begin
        if (cand_vld_q && !(armed_vld_q && (armed_idx_q == cand_idx_q))) begin
          cmd_time_d    = cand_time_q;
          cmd_payload_d = payload_q[cand_idx_q];
          armed_vld_d   = 1'b1;
          armed_idx_d   = cand_idx_q;
          data_wr_d     = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (req_evt_c) req_pend_d    = 1'b1;
    if (upd_evt_c) rescan_pend_d = 1'b1;

    if (FLUSH) begin
      state_d       = ST_IDLE;
      valid_d       = '0;
      count_d       = '0;
      armed_vld_d   = 1'b0;
      req_pend_d    = 1'b0;
      rescan_pend_d = 1'b0;
      cand_vld_d    = 1'b0;
      late_err_d    = 1'b0;
      data_wr_d     = 1'b0;
      stale_drop_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      valid_q       <= '0;
      count_q       <= '0;
      armed_vld_q   <= 1'b0;
      armed_idx_q   <= '0;
      req_hist_q    <= '0;
      upd_hist_q    <= '0;
      req_pend_q    <= 1'b0;
      rescan_pend_q <= 1'b0;
      scan_idx_q    <= '0;
      cand_vld_q    <= 1'b0;
      cand_idx_q    <= '0;
      cand_time_q   <= '0;
      data_wr_q     <= 1'b0;
      cmd_time_q    <= '0;
      cmd_payload_q <= '0;
      late_err_q    <= 1'b0;
      stale_drop_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      count_q       <= count_d;
      armed_vld_q   <= armed_vld_d;
      armed_idx_q   <= armed_idx_d;
      req_hist_q    <= {req_hist_q[1:0], REQ_COMM};
      upd_hist_q    <= {upd_hist_q[1:0], SYS_TIME_UPDATE};
      req_pend_q    <= req_pend_d;
      rescan_pend_q <= rescan_pend_d;
      scan_idx_q    <= scan_idx_d;
      cand_vld_q    <= cand_vld_d;
      cand_idx_q    <= cand_idx_d;
      cand_time_q   <= cand_time_d;
      data_wr_q     <= data_wr_d;
      cmd_time_q    <= cmd_time_d;
      cmd_payload_q <= cmd_payload_d;
      late_err_q    <= late_err_d;
      stale_drop_q  <= stale_drop_d;
    end
  end

  // Table contents are qualified by valid_q, so they need no reset
  always_ff @(posedge CLK) begin
    if (wr_en_c) begin
      time_q[free_idx_c]    <= WR_TIME;
      payload_q[free_idx_c] <= WR_PAYLOAD;
    end
  end

  assign DATA_WR       = data_wr_q;
  assign CMD_TIME_z    = cmd_time_q;
  assign CMD_PAYLOAD_z = cmd_payload_q;
  assign COUNT         = count_q;
  assign FULL          = full_c;
  assign LATE_ERR      = late_err_q;
  assign STALE_DROP    = stale_drop_q;

endmodule
